ddc_cic_cicc_cfg_rx: RTL and testbench
======================================

Name: ddc_cic_cicc_cfg_rx

Overview:
Downstream consumer of the channel filter-config sequencer's CIC/CICC word stream. It parses the serial config burst into CIC control registers and CICC post-scale and symmetry registers, and writes CICC coefficients into the inactive bank of a double-buffered coefficient RAM. All new settings commit atomically at end of burst, then the block returns ACK/Done to the sequencer.

Parameters:
CONFIG_WIDTH, 32, config word width
CIC_CONFIG_DATA_NUM, 3, header words: NUMSECS, DCEF, SCALE
CICC_FILTER_ORDER, 256, coefficient count is CICC_FILTER_ORDER+1 (257 words)
COEF_WIDTH, 18, coefficient width; low bits of each config word
COEF_ADDR_WIDTH, 9, coefficient RAM address width
CIC_MAX_SECS, 6, highest legal NUMSECS
CIC_MAX_DCEF, 4096, highest legal decimation factor

Ports:
CLK  in  1  clock
nRST  in  1  async active-low reset
isConfig  in  1  one-cycle start pulse; first word arrives the following cycle
Data_Config_In  in  CONFIG_WIDTH  config word, one per cycle, no gaps
isConfigACK  out  1  burst accepted/in progress
isConfigDone  out  1  one-cycle pulse, burst finished
CIC_NUMSECS  out  4  active CIC stage count
CIC_DCEF  out  16  active CIC decimation factor
CIC_SCALE  out  6  active CIC output shift
CICC_SCALVAL  out  6  active CICC output shift
CICC_isCoefSym  out  1  active symmetric-coefficient flag
Coef_WE  out  1  coefficient RAM write enable
Coef_WADDR  out  COEF_ADDR_WIDTH  coefficient address (0..CICC_FILTER_ORDER)
Coef_WDATA  out  COEF_WIDTH  coefficient data
Coef_Bank_Sel  out  1  bank the filter reads; writes always target ~Coef_Bank_Sel
Cfg_Updated  out  1  one-cycle pulse on commit; filters flush pipelines
Cfg_Error  out  1  last burst rejected

Behaviour:
- Reset: nRST asynchronous, active-low; clock CLK. All outputs 0, except CIC_NUMSECS=1, CIC_DCEF=2, CIC_SCALE=0. State machine enters IDLE.
- Burst length L = CIC_CONFIG_DATA_NUM + CICC_FILTER_ORDER + 3 = 262 words at defaults. Word order: NUMSECS, DCEF, SCALE, coef[0..256], SCALVAL, isCoefSym.
- States:
  - IDLE: isConfig → HDR, word index=0.
  - HDR: words 0..2 latched into shadow registers (low bits) → COEF.
  - COEF: each word drives Coef_WE=1, Coef_WADDR=index, Coef_WDATA=word[COEF_WIDTH-1:0]. Write is registered, 1 cycle after the word. After the last coefficient → TAIL.
  - TAIL: SCALVAL, then isCoefSym (bit 0) → CHECK.
  - CHECK: 1 cycle, validates shadow values → COMMIT.
  - COMMIT: 1 cycle. If valid: shadow→active, Coef_Bank_Sel toggles, Cfg_Updated=1, Cfg_Error=0. If invalid: active values and bank unchanged, Cfg_Error=1. isConfigDone=1 in both cases → IDLE.
- isConfigACK rises the cycle after isConfig and stays high through the Done cycle; it falls the cycle after Done.
- Latency: last word on cycle T → isConfigDone, Cfg_Updated and new outputs all visible on T+2.
- isConfig while not IDLE: abort and restart at word 0 next cycle. No commit, no Done, bank unchanged, ACK stays high. Partially written inactive bank is harmless and gets overwritten.
- isConfig coincident with COMMIT: commit completes (Done pulses), then HDR starts the next cycle.
- Word index counter saturates; no wrap. Coef_WADDR never exceeds CICC_FILTER_ORDER.
- Cfg_Error holds until the next commit.

Optional Feature:
DDC_CICC_CFG_RANGE_CHECK_EN.
- Defined: CHECK rejects if NUMSECS is 0 or >CIC_MAX_SECS, if DCEF <2 or >CIC_MAX_DCEF, or if SCALE or SCALVAL >47. Rejected bursts take the invalid-commit path.
- Undefined: every burst is valid, Cfg_Error is tied 0, and CHECK still occupies one cycle so latency is the same.

Test Plan:
- Reset → NUMSECS=1, DCEF=2, Bank_Sel=0, ACK/Done/WE=0.
- Burst NUMSECS=5, DCEF=64, SCALE=30, coef[i]=i, SCALVAL=17, sym=1 → 257 writes addr 0..256 data 0..256 to bank 1; Done, Cfg_Updated and Bank_Sel=1 two cycles after last word; outputs 5/64/30/17/1.
- Second burst coef[i]=1000+i → writes now hit bank 0, Bank_Sel→0 on commit; ACK high exactly L+2 cycles.
- isConfig re-pulsed at word 100 → no Done; restart, a full burst then commits correctly; ACK never drops.
- With DDC_CICC_CFG_RANGE_CHECK_EN, NUMSECS=0 → Done=1, Cfg_Error=1, actives and Bank_Sel unchanged, no Cfg_Updated; next valid burst clears Cfg_Error.
- nRST asserted mid-COEF → immediate defaults; fresh burst afterwards commits to bank 1.

Source files
------------

// File: rtl/ddc_cic_cicc_cfg_rx.sv
// CIC/CICC config-burst receiver: parses header, coefficients and tail into shadow
// registers, writes the inactive coefficient bank, commits atomically. Optional: DDC_CICC_CFG_RANGE_CHECK_EN.
module ddc_cic_cicc_cfg_rx #(
    parameter int CONFIG_WIDTH        = 32,
    parameter int CIC_CONFIG_DATA_NUM = 3,
    parameter int CICC_FILTER_ORDER   = 256,
    parameter int COEF_WIDTH          = 18,
    parameter int COEF_ADDR_WIDTH     = 9,
    parameter int CIC_MAX_SECS        = 6,
    parameter int CIC_MAX_DCEF        = 4096
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       isConfig,
    input  logic [CONFIG_WIDTH-1:0]    Data_Config_In,
    output logic                       isConfigACK,
    output logic                       isConfigDone,
    output logic [3:0]                 CIC_NUMSECS,
    output logic [15:0]                CIC_DCEF,
    output logic [5:0]                 CIC_SCALE,
    output logic [5:0]                 CICC_SCALVAL,
    output logic                       CICC_isCoefSym,
    output logic                       Coef_WE,
    output logic [COEF_ADDR_WIDTH-1:0] Coef_WADDR,
    output logic [COEF_WIDTH-1:0]      Coef_WDATA,
    output logic                       Coef_Bank_Sel,
    output logic                       Cfg_Updated,
    output logic                       Cfg_Error
);

    localparam int BURST_LEN = CIC_CONFIG_DATA_NUM + CICC_FILTER_ORDER + 3;
    localparam int IDXW      = $clog2(BURST_LEN + 1);

    localparam logic [IDXW-1:0] IDX_DCEF     = IDXW'(1);
    localparam logic [IDXW-1:0] IDX_SCALE    = IDXW'(2);
    localparam logic [IDXW-1:0] IDX_HDR_LAST = IDXW'(CIC_CONFIG_DATA_NUM - 1);
    localparam logic [IDXW-1:0] IDX_COEF0    = IDXW'(CIC_CONFIG_DATA_NUM);
    localparam logic [IDXW-1:0] IDX_COEF_END = IDXW'(CIC_CONFIG_DATA_NUM + CICC_FILTER_ORDER);
    localparam logic [IDXW-1:0] IDX_SCALVAL  = IDXW'(CIC_CONFIG_DATA_NUM + CICC_FILTER_ORDER + 1);
    localparam logic [IDXW-1:0] IDX_LAST     = IDXW'(BURST_LEN - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] HDR    = 3'd1;
    localparam logic [2:0] COEF   = 3'd2;
    localparam logic [2:0] TAIL   = 3'd3;
    localparam logic [2:0] CHECK  = 3'd4;
    localparam logic [2:0] COMMIT = 3'd5;

    logic [2:0]      state;
    logic [IDXW-1:0] wordIdx;
    logic [IDXW-1:0] coefOff;

    logic [3:0]  shNumsecs;
    logic [15:0] shDcef;
    logic [5:0]  shScale;
    logic [5:0]  shScalval;
    logic        shSym;
    logic        shValid;

    assign coefOff = wordIdx - IDX_COEF0;

    // Only the low bits of each word carry meaning; upper bits are don't-care.
    logic unusedHighBits;
    assign unusedHighBits = ^Data_Config_In[CONFIG_WIDTH-1:COEF_WIDTH];

`ifdef DDC_CICC_CFG_RANGE_CHECK_EN
    localparam logic [3:0]  MAX_SECS  = 4'(CIC_MAX_SECS);
    localparam logic [15:0] MAX_DCEF  = 16'(CIC_MAX_DCEF);
    localparam logic [5:0]  MAX_SHIFT = 6'd47;

    logic cfgErr;

    always_comb begin
        shValid = 1'b1;
        if (shNumsecs == 4'd0 || shNumsecs > MAX_SECS) shValid = 1'b0;
        if (shDcef < 16'd2 || shDcef > MAX_DCEF)        shValid = 1'b0;
        if (shScale > MAX_SHIFT || shScalval > MAX_SHIFT) shValid = 1'b0;
    end

    assign Cfg_Error = cfgErr;
`else
    assign shValid   = 1'b1;
    assign Cfg_Error = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state          <= IDLE;
            wordIdx        <= '0;
            isConfigACK    <= 1'b0;
            isConfigDone   <= 1'b0;
            Cfg_Updated    <= 1'b0;
            Coef_WE        <= 1'b0;
            Coef_WADDR     <= '0;
            Coef_WDATA     <= '0;
            Coef_Bank_Sel  <= 1'b0;
            CIC_NUMSECS    <= 4'd1;
            CIC_DCEF       <= 16'd2;
            CIC_SCALE      <= 6'd0;
            CICC_SCALVAL   <= 6'd0;
            CICC_isCoefSym <= 1'b0;
            shNumsecs      <= 4'd1;
            shDcef         <= 16'd2;
            shScale        <= 6'd0;
            shScalval      <= 6'd0;
            shSym          <= 1'b0;
`ifdef DDC_CICC_CFG_RANGE_CHECK_EN
            cfgErr         <= 1'b0;
`endif
        end else begin
            Coef_WE      <= 1'b0;
            isConfigDone <= 1'b0;
            Cfg_Updated  <= 1'b0;
            if (wordIdx != IDX_LAST) wordIdx <= wordIdx + 1'b1;

            // A start pulse anywhere restarts the burst; an in-flight CHECK is dropped,
            // but a COMMIT already under way has published its results the edge before.
            if (isConfig) begin
                state       <= HDR;
                wordIdx     <= '0;
                isConfigACK <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    HDR: begin
                        if (wordIdx == '0)            shNumsecs <= Data_Config_In[3:0];
                        else if (wordIdx == IDX_DCEF)  shDcef    <= Data_Config_In[15:0];
                        else if (wordIdx == IDX_SCALE) shScale   <= Data_Config_In[5:0];
                        if (wordIdx == IDX_HDR_LAST) state <= COEF;
                    end
                    COEF: begin
                        Coef_WE    <= 1'b1;
                        Coef_WADDR <= COEF_ADDR_WIDTH'(coefOff);
                        Coef_WDATA <= Data_Config_In[COEF_WIDTH-1:0];
                        if (wordIdx == IDX_COEF_END) state <= TAIL;
                    end
                    TAIL: begin
                        if (wordIdx == IDX_SCALVAL) begin
                            shScalval <= Data_Config_In[5:0];
                        end else begin
                            shSym <= Data_Config_In[0];
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        // Results register here so they are visible during COMMIT.
                        state        <= COMMIT;
                        isConfigDone <= 1'b1;
                        if (shValid) begin
                            CIC_NUMSECS    <= shNumsecs;
                            CIC_DCEF       <= shDcef;
                            CIC_SCALE      <= shScale;
                            CICC_SCALVAL   <= shScalval;
                            CICC_isCoefSym <= shSym;
                            Coef_Bank_Sel  <= ~Coef_Bank_Sel;
                            Cfg_Updated    <= 1'b1;
                        end
`ifdef DDC_CICC_CFG_RANGE_CHECK_EN
                        cfgErr <= ~shValid;
`endif
                    end
                    COMMIT: begin
                        state       <= IDLE;
                        isConfigACK <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddc_cic_cicc_cfg_rx.sv
// Self-checking bench for ddc_cic_cicc_cfg_rx: table-driven bursts, corner sequences and
// randomized bursts against a word-level model of the expected register and RAM effects.
module tb_ddc_cic_cicc_cfg_rx;

    localparam int L     = 262;
    localparam int HN    = 3;
    localparam int NCOEF = 257;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        isConfig;
    logic [31:0] Data_Config_In;
    logic        isConfigACK, isConfigDone, CICC_isCoefSym, Coef_WE, Coef_Bank_Sel;
    logic        Cfg_Updated, Cfg_Error;
    logic [3:0]  CIC_NUMSECS;
    logic [15:0] CIC_DCEF;
    logic [5:0]  CIC_SCALE, CICC_SCALVAL;
    logic [8:0]  Coef_WADDR;
    logic [17:0] Coef_WDATA;

    always #5 CLK = ~CLK;

    ddc_cic_cicc_cfg_rx dut (
        .CLK(CLK), .nRST(nRST), .isConfig(isConfig), .Data_Config_In(Data_Config_In),
        .isConfigACK(isConfigACK), .isConfigDone(isConfigDone),
        .CIC_NUMSECS(CIC_NUMSECS), .CIC_DCEF(CIC_DCEF), .CIC_SCALE(CIC_SCALE),
        .CICC_SCALVAL(CICC_SCALVAL), .CICC_isCoefSym(CICC_isCoefSym),
        .Coef_WE(Coef_WE), .Coef_WADDR(Coef_WADDR), .Coef_WDATA(Coef_WDATA),
        .Coef_Bank_Sel(Coef_Bank_Sel), .Cfg_Updated(Cfg_Updated), .Cfg_Error(Cfg_Error)
    );

    typedef struct {
        logic [31:0] num, dcef, scale, scalval, sym;
        bit          coefRnd;
        int          coefBase;
        bit          expValid;   // expected acceptance when range checking is built in
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Model of the active configuration visible to the filters
    int mNum = 1, mDcef = 2, mScale = 0, mScalval = 0, mSym = 0, mBank = 0, mErr = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic bit rangeOk(input int n, input int d, input int s, input int sv);
        return (n >= 1) && (n <= 6) && (d >= 2) && (d <= 4096) && (s <= 47) && (sv <= 47);
    endfunction

    function automatic vec_t mk(input int n, input int d, input int s, input int sv,
                                input int sy, input bit rnd, input int base, input bit ok);
        vec_t v;
        v.num = n; v.dcef = d; v.scale = s; v.scalval = sv; v.sym = sy;
        v.coefRnd = rnd; v.coefBase = base; v.expValid = ok;
        return v;
    endfunction

    function automatic vec_t rndVec();
        vec_t v;
        v.num     = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 8));
        v.dcef    = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 5000));
        v.scale   = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 50));
        v.scalval = ($urandom & 32'hFFFF_FFC0) | 32'($urandom_range(0, 50));
        v.sym     = $urandom;
        v.coefRnd = 1'b1;
        v.coefBase = 0;
        v.expValid = rangeOk(int'(v.num[3:0]), int'(v.dcef[15:0]),
                             int'(v.scale[5:0]), int'(v.scalval[5:0]));
        return v;
    endfunction

    // pre: start pulse already issued by the previous call; chain: pulse during Done;
    // abortAt >= 0: stop before that word so the caller can re-pulse or reset.
    task automatic burst(input vec_t v, input int abortAt, input bit pre, input bit chain);
        logic [31:0] w[L];
        int ackCnt = 0, wrErr = 0, doneErr = 0, bankErr = 0;
        bit valid;
        w[0] = v.num; w[1] = v.dcef; w[2] = v.scale;
        for (int i = 0; i < NCOEF; i++) w[HN+i] = v.coefRnd ? $urandom : 32'(v.coefBase + i);
        w[L-2] = v.scalval; w[L-1] = v.sym;

        if (!pre) begin
            isConfig = 1'b1;
            tick();
        end
        isConfig = 1'b0;
        for (int k = 0; k < L; k++) begin
            if (abortAt >= 0 && k == abortAt) begin
                chk("abort_ack_high", isConfigACK, 1);
                chk("abort_no_done", doneErr, 0);
                chk("abort_writes", wrErr, 0);
                return;
            end
            ackCnt += int'(isConfigACK);
            Data_Config_In = w[k];
            tick();
            if (k >= HN && k < HN + NCOEF) begin
                if (Coef_WE !== 1'b1 || Coef_WADDR !== 9'(k - HN) || Coef_WDATA !== w[k][17:0]) begin
                    if (wrErr == 0)
                        $display("  write k=%0d we=%0b addr=%0d data=%0h", k, Coef_WE, Coef_WADDR, Coef_WDATA);
                    wrErr++;
                end
            end else if (Coef_WE !== 1'b0) wrErr++;
            if (isConfigDone !== 1'b0) doneErr++;
            if (Coef_Bank_Sel !== 1'(mBank)) bankErr++;
        end
        ackCnt += int'(isConfigACK);
        if (isConfigDone !== 1'b0) doneErr++;
        tick();
        ackCnt += int'(isConfigACK);

`ifdef DDC_CICC_CFG_RANGE_CHECK_EN
        valid = v.expValid;
`else
        valid = 1'b1;
`endif
        if (valid) begin
            mNum = int'(v.num[3:0]); mDcef = int'(v.dcef[15:0]); mScale = int'(v.scale[5:0]);
            mScalval = int'(v.scalval[5:0]); mSym = int'(v.sym[0]); mBank ^= 1; mErr = 0;
        end else mErr = 1;

        chk("coef_writes", wrErr, 0);
        chk("early_done", doneErr, 0);
        chk("bank_during_burst", bankErr, 0);
        chk("ack_cycles", ackCnt, L + 2);
        chk("done", isConfigDone, 1);
        chk("updated", Cfg_Updated, valid);
        chk("numsecs", CIC_NUMSECS, mNum);
        chk("dcef", CIC_DCEF, mDcef);
        chk("scale", CIC_SCALE, mScale);
        chk("scalval", CICC_SCALVAL, mScalval);
        chk("sym", CICC_isCoefSym, mSym);
        chk("bank", Coef_Bank_Sel, mBank);
        chk("error", Cfg_Error, mErr);
        if (chain) begin
            isConfig = 1'b1;
            tick();
            return;
        end
        tick();
        chk("ack_fall", isConfigACK, 0);
        chk("done_pulse", isConfigDone, 0);
        chk("updated_pulse", Cfg_Updated, 0);
    endtask

    task automatic chkDefaults(input string tag);
        chk({tag, "_numsecs"}, CIC_NUMSECS, 1);
        chk({tag, "_dcef"}, CIC_DCEF, 2);
        chk({tag, "_scale"}, CIC_SCALE, 0);
        chk({tag, "_bank"}, Coef_Bank_Sel, 0);
        chk({tag, "_ack"}, isConfigACK, 0);
        chk({tag, "_done"}, isConfigDone, 0);
        chk({tag, "_we"}, Coef_WE, 0);
        chk({tag, "_err"}, Cfg_Error, 0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = mk(5, 64, 30, 17, 1, 0, 0, 1);
        tbl[1] = mk(3, 128, 10, 12, 0, 0, 1000, 1);
        tbl[2] = mk(6, 4096, 47, 47, 0, 1, 0, 1);
        tbl[3] = mk(1, 2, 0, 0, 1, 1, 0, 1);
        tbl[4] = mk(0, 64, 10, 10, 1, 1, 0, 0);
        tbl[5] = mk(7, 64, 10, 10, 1, 1, 0, 0);
        tbl[6] = mk(3, 1, 10, 10, 0, 1, 0, 0);
        tbl[7] = mk(3, 4097, 10, 10, 0, 1, 0, 0);
        tbl[8] = mk(3, 100, 48, 5, 1, 1, 0, 0);
        tbl[9] = mk(2, 300, 12, 48, 1, 1, 0, 0);

        nRST = 1'b0; isConfig = 1'b0; Data_Config_In = '0;
        #12;
        chkDefaults("reset");
        nRST = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) burst(tbl[i], -1, 0, 0);
        burst(mk(2, 300, 12, 9, 1, 1, 0, 1), -1, 0, 0);

        // re-pulse at word 100, then a full burst must still commit
        burst(tbl[3], 100, 0, 0);
        burst(tbl[0], -1, 0, 0);

        // start pulse coincident with the commit cycle
        burst(tbl[1], -1, 0, 1);
        burst(tbl[2], -1, 1, 0);

        for (int i = 0; i < 6; i++) burst(rndVec(), -1, 0, 0);

        // asynchronous reset in the middle of the coefficient phase
        burst(rndVec(), 50, 0, 0);
        #2 nRST = 1'b0;
        #1;
        chkDefaults("midreset");
        mNum = 1; mDcef = 2; mScale = 0; mScalval = 0; mSym = 0; mBank = 0; mErr = 0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();
        burst(tbl[0], -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
